lzs_bit_unpacker: RTL

- Parametrised bit-stream source for the LZS decoder.
- Accepts packed compressed words from an upstream word FIFO or DMA port.
- Presents an MSB-first window of IN_WIDTH bits to the decoder, which consumes a variable number of bits per token.
- Generalises the fixed 13-bit stream source: configurable word/window/buffer widths, end-of-stream tail handling, back-to-back stream restart and an underflow flag.

---
 rtl/lzs_bit_unpacker.sv | 95 +++++++++
 1 files changed

// File: rtl/lzs_bit_unpacker.sv
// Bit-stream source for the LZS decoder: packs upstream words into a left-aligned
// bit buffer and presents an MSB-first window of IN_WIDTH bits to the decoder.
module lzs_bit_unpacker #(
  parameter int unsigned IN_WIDTH       = 13,
  parameter int unsigned NEED_STR_WIDTH = 4,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned BUF_WIDTH      = 64,
  parameter int unsigned LVL_WIDTH      = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WORD_WIDTH-1:0]     in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      stream_valid,
  output logic [IN_WIDTH-1:0]       stream_data,
  input  logic                      stream_ack,
  input  logic [NEED_STR_WIDTH-1:0] stream_width,
  output logic                      stream_empty,
  output logic [LVL_WIDTH-1:0]      level,
  output logic                      err_underflow
);

  localparam int unsigned PAD_WIDTH = BUF_WIDTH - WORD_WIDTH;
  localparam logic [LVL_WIDTH-1:0]      IN_LVL   = LVL_WIDTH'(IN_WIDTH);
  localparam logic [LVL_WIDTH-1:0]      WORD_LVL = LVL_WIDTH'(WORD_WIDTH);
  localparam logic [LVL_WIDTH-1:0]      ROOM_LVL = LVL_WIDTH'(PAD_WIDTH);
  localparam logic [NEED_STR_WIDTH-1:0] IN_W     = NEED_STR_WIDTH'(IN_WIDTH);

  logic [BUF_WIDTH-1:0]      bits_q, bits_s, bits_n;
  logic [LVL_WIDTH-1:0]      level_q, level_s, level_n;
  logic                      last_seen_q, last_seen_n;
  logic                      err_q, err_n;
  logic                      accept, consume, illegal;
  logic [NEED_STR_WIDTH-1:0] w_eff;
  logic [BUF_WIDTH-1:0]      word_aligned;

  // Outputs decode registered state only; no input-to-output path.
  assign in_ready      = (!last_seen_q || (level_q == '0)) && (level_q <= ROOM_LVL);
  assign stream_valid  = (level_q >= IN_LVL) || (last_seen_q && (level_q != '0));
  assign stream_data   = bits_q[BUF_WIDTH-1 -: IN_WIDTH];
  assign stream_empty  = last_seen_q && (level_q == '0);
  assign level         = level_q;
  assign err_underflow = err_q;

  assign accept       = in_valid && in_ready;
  assign consume      = stream_ack && stream_valid;
  assign illegal      = stream_width > IN_W;
  assign w_eff        = illegal ? IN_W : stream_width;
  assign word_aligned = {in_data, {PAD_WIDTH{1'b0}}};

  // Consume shifts first; an accepted word then lands right after the surviving bits.
  always_comb begin
    bits_s      = bits_q;
    level_s     = level_q;
    err_n       = err_q;
    bits_n      = bits_q;
    level_n     = level_q;
    last_seen_n = last_seen_q;
    if (consume) begin
      if (illegal) err_n = 1'b1;
      if (LVL_WIDTH'(w_eff) > level_q) begin
        bits_s  = '0;
        level_s = '0;
        err_n   = 1'b1;
      end else begin
        bits_s  = bits_q << w_eff;
        level_s = level_q - LVL_WIDTH'(w_eff);
      end
    end
    bits_n  = bits_s;
    level_n = level_s;
    if (accept) begin
      bits_n      = bits_s | (word_aligned >> level_s);
      level_n     = level_s + WORD_LVL;
      last_seen_n = in_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_q      <= '0;
      level_q     <= '0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bits_q      <= bits_n;
      level_q     <= level_n;
      last_seen_q <= last_seen_n;
      err_q       <= err_n;
    end
  end

endmodule
